// File: rtl/systolic_feeder.sv
// systolic_feeder: fetches DIM matrix rows into the transpose FIFO bank, then
// issues per-FIFO shift enables skewed by one cycle per column index.
module systolic_feeder #(
   parameter int DIM    = 8,
   parameter int BITS   = 8,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic                mem_rd,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_vld,
   input  logic [DIM*BITS-1:0] mem_data,
   output logic [BITS-1:0]     row_d [DIM],
   output logic [DIM-1:0]      wr_en,
   output logic [DIM-1:0]      shift_en,
   output logic                busy,
   output logic                done
);

   localparam int R_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int T_W = $clog2(2 * DIM);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(DIM * BITS / 8);
   localparam logic [R_W-1:0]    R_LAST   = R_W'(DIM - 1);
   localparam logic [T_W-1:0]    T_LAST   = T_W'(2 * DIM - 2);
   localparam logic [DIM-1:0]    WR_ONE   = DIM'(1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM,
      DONE
   } state_t;

   state_t         state;
   logic [R_W-1:0] r_cnt;
   logic [T_W-1:0] t_cnt;

   // Column k is live for the DIM stream steps starting at step k.
   function automatic logic [DIM-1:0] skew_mask(input int t);
      logic [DIM-1:0] m;
      m = '0;
      for (int k = 0; k < DIM; k++) begin
         m[k] = (t >= k) && (t <= k + DIM - 1);
      end
      return m;
   endfunction

   // In LOAD, mem_rd already low means the last row was written last cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         r_cnt    <= '0;
         t_cnt    <= '0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         wr_en    <= '0;
         shift_en <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int j = 0; j < DIM; j++) begin
            row_d[j] <= '0;
         end
      end else begin
         wr_en <= '0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  r_cnt    <= '0;
                  mem_rd   <= 1'b1;
                  mem_addr <= base_addr;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               if (!mem_rd) begin
                  state    <= STREAM;
                  t_cnt    <= '0;
                  shift_en <= skew_mask(0);
               end else if (mem_vld) begin
                  for (int j = 0; j < DIM; j++) begin
                     row_d[j] <= mem_data[j*BITS +: BITS];
                  end
                  wr_en <= WR_ONE << r_cnt;
                  if (r_cnt == R_LAST) begin
                     mem_rd <= 1'b0;
                  end else begin
                     mem_addr <= mem_addr + ROW_STEP;
                     r_cnt    <= r_cnt + 1'b1;
                  end
               end
            end
            STREAM: begin
               if (t_cnt == T_LAST) begin
                  state    <= DONE;
                  shift_en <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  t_cnt    <= t_cnt + 1'b1;
                  shift_en <= skew_mask(int'(t_cnt) + 1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder: cycle-exact timing of
// loads, skewed streaming, wait states, spurious inputs, reset and address wrap.
module tb_systolic_feeder;

   localparam int DIM    = 8;
   localparam int BITS   = 8;
   localparam int ADDR_W = 32;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic [ADDR_W-1:0]   base_addr;
   logic                mem_rd;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_vld;
   logic [DIM*BITS-1:0] mem_data;
   logic [BITS-1:0]     row_d [DIM];
   logic [DIM-1:0]      wr_en;
   logic [DIM-1:0]      shift_en;
   logic                busy;
   logic                done;

   logic       w_start;
   logic [7:0] w_base;
   logic       w_mem_rd;
   logic [7:0] w_mem_addr;
   logic       w_mem_vld;
   logic [63:0] w_mem_data;
   logic [7:0] w_row_d [8];
   logic [7:0] w_wr_en;
   logic [7:0] w_shift_en;
   logic       w_busy;
   logic       w_done;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   systolic_feeder #(.DIM(DIM), .BITS(BITS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_vld(mem_vld), .mem_data(mem_data),
      .row_d(row_d), .wr_en(wr_en), .shift_en(shift_en), .busy(busy), .done(done)
   );

   systolic_feeder #(.DIM(8), .BITS(8), .ADDR_W(8)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .start(w_start), .base_addr(w_base),
      .mem_rd(w_mem_rd), .mem_addr(w_mem_addr), .mem_vld(w_mem_vld), .mem_data(w_mem_data),
      .row_d(w_row_d), .wr_en(w_wr_en), .shift_en(w_shift_en), .busy(w_busy), .done(w_done)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] rowVal(input int r);
      logic [63:0] v;
      v = 64'h0807060504030201 + 64'(r) * 64'h0808080808080808;
      return v;
   endfunction

   function automatic logic [63:0] packRow();
      logic [63:0] p;
      p = '0;
      for (int j = 0; j < DIM; j++) p[j*BITS +: BITS] = row_d[j];
      return p;
   endfunction

   // Ramp-up then ramp-down of the live-column mask for DIM=8.
   function automatic logic [DIM-1:0] expMask(input int t);
      logic [15:0] m;
      if (t < DIM) m = (16'd1 << (t + 1)) - 16'd1;
      else         m = 16'h00FF << (t - DIM + 1);
      return m[DIM-1:0];
   endfunction

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_mem_rd"}, mem_rd, 1'b0);
      checkOutput({tag, "_mem_addr"}, mem_addr, '0);
      checkOutput({tag, "_row_d"}, packRow(), '0);
      checkOutput({tag, "_wr_en"}, wr_en, '0);
      checkOutput({tag, "_shift_en"}, shift_en, '0);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_done"}, done, 1'b0);
   endtask

   // One full job; wait_row=DIM means zero-wait memory throughout.
   task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int wait_row,
                                input int wait_cyc, input bit spurious);
      int v [DIM];
      int hi_cnt [DIM];
      int w, last_c, stream_c0, held, req, t;
      logic prev_rd;
      logic [ADDR_W-1:0] prev_addr;
      logic [ADDR_W-1:0] ea;
      logic [DIM-1:0] exp_wr;
      w = (wait_row < DIM) ? wait_cyc : 0;
      for (int r = 0; r < DIM; r++) begin
         v[r] = 1 + r + ((r >= wait_row) ? wait_cyc : 0);
         hi_cnt[r] = 0;
      end
      stream_c0 = DIM + 2 + w;
      last_c = 3 * DIM + 1 + w;
      held = 0;
      prev_rd = 1'b0;
      prev_addr = '0;
      @(negedge clk);
      start = 1'b1;
      base_addr = base;
      mem_vld = 1'b0;
      for (int c = 1; c <= last_c + 1; c++) begin
         @(negedge clk);
         checkOutput("busy", busy, (c <= last_c - 1));
         checkOutput("done", done, (c == last_c));
         checkOutput("mem_rd", mem_rd, (c <= v[DIM-1]));
         exp_wr = '0;
         for (int r = 0; r < DIM; r++) begin
            if (c == v[r] + 1) begin
               exp_wr[r] = 1'b1;
               checkOutput("row_d", packRow(), rowVal(r));
            end
         end
         checkOutput("wr_en", wr_en, exp_wr);
         if (c <= v[DIM-1]) begin
            req = DIM - 1;
            for (int r = DIM - 1; r >= 0; r--) if (v[r] >= c) req = r;
            ea = base + ADDR_W'(req * DIM * BITS / 8);
            checkOutput("mem_addr", mem_addr, ea);
         end
         t = c - stream_c0;
         checkOutput("shift_en", shift_en, (t >= 0 && t <= 2 * DIM - 2) ? expMask(t) : '0);
         for (int k = 0; k < DIM; k++) if (shift_en[k]) hi_cnt[k]++;
         start = 1'b0;
         if (mem_rd && prev_rd && mem_addr == prev_addr) held++;
         else held = 0;
         prev_rd = mem_rd;
         prev_addr = mem_addr;
         mem_vld = 1'b0;
         if (mem_rd) begin
            req = int'((mem_addr - base) / ADDR_W'(DIM * BITS / 8));
            mem_data = rowVal(req);
            mem_vld = (held >= ((req == wait_row) ? wait_cyc : 0));
         end
         if (spurious) begin
            if (t == 3) begin
               mem_vld = 1'b1;
               mem_data = '1;
            end
            if (c == 3 || t == 4 || c == last_c) start = 1'b1;
         end
      end
      start = 1'b0;
      mem_vld = 1'b0;
      for (int k = 0; k < DIM; k++) checkOutput("shift_cnt", hi_cnt[k], DIM);
   endtask

   // Reset two cycles mid-STREAM, with a late mem_vld around the reset.
   task automatic applyReset();
      logic [ADDR_W-1:0] base;
      base = 32'h100;
      @(negedge clk);
      start = 1'b1;
      base_addr = base;
      for (int c = 1; c <= DIM + 5; c++) begin
         @(negedge clk);
         start = 1'b0;
         mem_vld = mem_rd;
         mem_data = rowVal(int'((mem_addr - base) / ADDR_W'(DIM * BITS / 8)));
      end
      checkOutput("pre_reset_busy", busy, 1'b1);
      rst_n = 1'b0;
      mem_vld = 1'b1;
      @(negedge clk);
      checkIdleZero("reset1");
      @(negedge clk);
      checkIdleZero("reset2");
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("late_vld_wr_en", wr_en, '0);
      checkOutput("late_vld_busy", busy, 1'b0);
      mem_vld = 1'b0;
   endtask

   task automatic applyWrap();
      int n;
      bit saw_done;
      logic [7:0] ea;
      n = 0;
      saw_done = 1'b0;
      @(negedge clk);
      w_start = 1'b1;
      w_base = 8'hF0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         w_start = 1'b0;
         if (w_done) saw_done = 1'b1;
         w_mem_vld = w_mem_rd;
         w_mem_data = rowVal(n);
         if (w_mem_rd) begin
            ea = 8'hF0 + 8'(n * 8);
            if (n < 8) checkOutput("wrap_addr", w_mem_addr, ea);
            n++;
         end
      end
      w_mem_vld = 1'b0;
      checkOutput("wrap_reads", n, 8);
      checkOutput("wrap_done", saw_done, 1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      base_addr = '0;
      mem_vld = 1'b0;
      mem_data = '0;
      w_start = 1'b0;
      w_base = '0;
      w_mem_vld = 1'b0;
      w_mem_data = '0;
      repeat (2) @(negedge clk);
      checkIdleZero("init");
      rst_n = 1'b1;

      $display("[TB] zero-wait job");
      applyStimulus(32'h100, DIM, 0, 1'b0);

      $display("[TB] mem_vld pulse in IDLE");
      @(negedge clk);
      mem_vld = 1'b1;
      mem_data = rowVal(5);
      @(negedge clk);
      checkOutput("idle_vld_wr_en", wr_en, '0);
      checkOutput("idle_vld_mem_rd", mem_rd, 1'b0);
      mem_vld = 1'b0;

      $display("[TB] wait states on row 2");
      applyStimulus(32'h100, 2, 3, 1'b0);

      $display("[TB] spurious start and mem_vld");
      applyStimulus(32'h200, DIM, 0, 1'b1);

      $display("[TB] reset mid-stream then new job");
      applyReset();
      applyStimulus(32'h100, DIM, 0, 1'b0);

      $display("[TB] address wrap");
      applyWrap();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream control stage for the bank of DIM transpose FIFOs that feed the systolic array. It fetches DIM matrix rows from memory, loads each row into its own FIFO with a one-hot write pulse, then issues per-FIFO shift enables skewed by one cycle per index, so the array receives diagonally staggered operands. One instance drives one operand matrix (A or B).

## Interface
- DIM, 8, matrix dimension; number of FIFOs driven and elements per row
- BITS, 8, element width; DIM*BITS must be a multiple of 8
- ADDR_W, 32, byte-address width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle job request; sampled only in IDLE
- base_addr  in  ADDR_W  byte address of row 0; captured on accepted start
- mem_rd  out  1  read request; held high until mem_vld
- mem_addr  out  ADDR_W  byte address of the requested row
- mem_vld  in  1  one-cycle read-data strobe; ignored while mem_rd=0
- mem_data  in  DIM*BITS  row word; element j = mem_data[j*BITS +: BITS]
- row_d  out  DIM x BITS (unpacked)  registered row for the FIFO d inputs; row_d[j] = element j
- wr_en  out  DIM  one-hot; bit r loads FIFO r from row_d
- shift_en  out  DIM  per-FIFO shift enable; also marks FIFO r's q as live for the array
- busy  out  1  high in LOAD and STREAM
- done  out  1  one-cycle pulse when the job completes

## Operation
- States: IDLE, LOAD, STREAM, DONE. Row counter r is 0..DIM-1. Stream counter t is 0..2*DIM-2.
- IDLE: start=1 captures base_addr, sets r=0, and moves to LOAD. mem_rd=1 and mem_addr=base_addr from the next cycle.
- LOAD: wait for mem_vld while holding mem_rd and mem_addr stable.
- LOAD, on mem_vld: register mem_data into row_d and assert wr_en[r] in the next cycle only.
- LOAD, if r<DIM-1: in that same next cycle, mem_addr += DIM*BITS/8, mem_rd stays high, r increments.
- LOAD, if r=DIM-1: mem_rd drops that cycle, and the FSM enters STREAM in the following cycle with t=0.
- STREAM: shift_en[k] = (t >= k) && (t <= k+DIM-1). Exactly DIM bits of shift_en are high per column over the job.
- STREAM, at t=2*DIM-2: go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. start is ignored during the DONE cycle.
- Address arithmetic is ADDR_W-bit unsigned and wraps modulo 2^ADDR_W.
- row_d holds its last value outside wr_en cycles. The FIFO ignores row_d unless wr_en is high.
- start while busy or in DONE: ignored, no queuing.
- Reset (any state, mid-job included), outputs on the next edge:
  - mem_rd=0, mem_addr=0, row_d all 0, wr_en=0, shift_en=0, busy=0, done=0
  - FSM returns to IDLE; an in-flight read is abandoned and a late mem_vld is ignored.

## Timing
- start accepted at edge E: busy=1 and mem_rd=1 from cycle E+1.
- mem_vld at cycle V: wr_en[r] and row_d valid in cycle V+1. The next request is visible in cycle V+1, so the earliest next mem_vld is V+1.
- With zero-wait memory (mem_vld in the first cycle of each request):
  - wr_en pulses fall in cycles E+2 .. E+DIM+1.
  - STREAM spans cycles E+DIM+2 .. E+3*DIM.
  - done pulses in cycle E+3*DIM+1.
- Within STREAM, shift_en[k] rises exactly k cycles after shift_en[0] and stays high for DIM consecutive cycles.
- No combinational path from any input to any output.

## Test plan
- Reset: hold rst_n=0 two cycles mid-STREAM (DIM=8, BITS=8) -> next cycle all outputs 0; start one cycle later is accepted normally.
- Zero-wait job: base_addr=0x100, rows 0x0807060504030201+r*0x0808080808080808 -> mem_addr 0x100,0x108,...,0x138.
  - wr_en one-hot 0x01..0x80 with matching row_d; row_d[0]=0x01 on the first pulse.
  - done at start+25 cycles.
- Skew check: in STREAM, shift_en sequence is 0x01,0x03,0x07,...,0xFF (t=7), then 0xFE,0xFC,...,0x80 (t=14).
  - Each bit is high exactly 8 cycles.
  - Golden model: through attached fifo_transpose instances, the array sees element t-k at column k.
- Wait states: mem_vld delayed 3 cycles on row 2 -> mem_rd and mem_addr 0x110 held stable; no wr_en during the wait; done delayed by exactly 3 cycles.
- Spurious inputs: mem_vld pulsed in IDLE and during STREAM -> no wr_en. start pulsed in LOAD, STREAM and DONE -> ignored; busy/done timing unchanged.
- Address wrap: ADDR_W=8, base_addr=0xF0 -> mem_addr 0xF0,0xF8,0x00,...,0x28.
